// File: rtl/keycode_pkg.sv
// Shared definitions for the keycode PIO arbiter: FSM encoding, PIO address and keycode width.
package keycode_pkg;

   localparam int unsigned KEY_W    = 8;
   localparam int unsigned GRANT_W  = 3;
   localparam logic [1:0]  PIO_ADDR = 2'd0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWr   = 2'd1,
      StRd   = 2'd2,
      StHold = 2'd3
   } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after last_grant+1 (wrapping).
module rr_picker
   import keycode_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [GRANT_W-1:0] i_last_grant,
   output logic [GRANT_W-1:0] o_grant,
   output logic               o_grant_valid
);

   always_comb begin
      int unsigned idx;
      o_grant       = '0;
      o_grant_valid = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         // last_grant < NUM_REQ, so one subtraction is enough to wrap
         idx = 32'(i_last_grant) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!o_grant_valid && (j == idx) && i_req[j]) begin
               o_grant_valid = 1'b1;
               o_grant       = GRANT_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/keycode_pio_arbiter.sv
// Arbitrates keycode writes from several requesters onto one PIO register, verifying each
// write by readback and enforcing an idle gap between writes.
module keycode_pio_arbiter
   import keycode_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [KEY_W*NUM_REQ-1:0] req_keycode,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [1:0]               avm_address,
   output logic                     avm_chipselect,
   output logic                     avm_write_n,
   output logic [31:0]              avm_writedata,
   input  logic [31:0]              avm_readdata,
   output logic                     busy,
   output logic [GRANT_W-1:0]       last_grant,
   output logic                     mismatch,
   output logic [7:0]               mismatch_count
);

   localparam int unsigned HCW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HCW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [KEY_W-1:0]   r_keycode;
   logic [KEY_W-1:0]   w_keycode_sel;
   logic [GRANT_W-1:0] r_grant;
   logic [GRANT_W-1:0] w_pick;
   logic               w_pick_valid;
   logic [HCW-1:0]     r_hold_cnt;
   logic               r_mismatch;
   logic [7:0]         r_mm_count;
   logic               w_rd_mismatch;
   logic               w_unused_rd;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_picker (
      .i_req         (req_valid),
      .i_last_grant  (r_grant),
      .o_grant       (w_pick),
      .o_grant_valid (w_pick_valid)
   );

   always_comb begin
      w_keycode_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_pick == GRANT_W'(i)) begin
            w_keycode_sel = req_keycode[i*KEY_W +: KEY_W];
         end
      end
   end

   // Only the keycode byte of the readback is meaningful
   assign w_rd_mismatch = (avm_readdata[KEY_W-1:0] != r_keycode);
   assign w_unused_rd   = ^avm_readdata[31:KEY_W];

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_pick_valid) w_state_nxt = StWr;
         StWr:    w_state_nxt = StRd;
         StRd:    w_state_nxt = (HOLD_CYCLES == 0) ? StIdle : StHold;
         StHold:  if (r_hold_cnt == '0) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_keycode  <= '0;
         r_grant    <= GRANT_W'(NUM_REQ - 1);
         r_hold_cnt <= '0;
         r_mismatch <= 1'b0;
         r_mm_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_mismatch <= (r_state == StRd) && w_rd_mismatch;
         if ((r_state == StIdle) && w_pick_valid) begin
            r_grant   <= w_pick;
            r_keycode <= w_keycode_sel;
         end
         if (r_state == StRd) begin
            r_hold_cnt <= HOLD_LOAD;
         end else if ((r_state == StHold) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
         end
         if ((r_state == StRd) && w_rd_mismatch && (r_mm_count != 8'hFF)) begin
            r_mm_count <= r_mm_count + 8'd1;
         end
      end
   end

   always_comb begin
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_address    = PIO_ADDR;
      avm_writedata  = '0;
      req_ready      = '0;
      case (r_state)
         StWr: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_writedata  = {{(32-KEY_W){1'b0}}, r_keycode};
         end
         StRd: begin
            avm_chipselect = 1'b1;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (r_grant == GRANT_W'(i));
            end
         end
         default: ;
      endcase
   end

   assign busy           = (r_state != StIdle);
   assign last_grant     = r_grant;
   assign mismatch       = r_mismatch;
   assign mismatch_count = r_mm_count;

endmodule
